// File: rtl/sequenciador_varredura.sv
// -----------------------------------------------------------------------------
// sequenciador_varredura
// Scan sequencer feeding the select/enable pair of the 3-to-8 decoder.
// A start request in IDLE launches a scan through every select address.
// Each address is held with enable high for DWELL cycles.
// The scan makes one pass (modo_continuo=0) or wraps forever (modo_continuo=1).
//
// Optional feature macro: SEQ_REVERSO_EN
//   When defined, the 'reverso' input is present. reverso=1 on the start edge
//   makes the scan run downward from 2^N_SEL-1 to 0. The direction is latched
//   for the whole scan.
//   When undefined, the port does not exist and the scan always counts up.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous reset, active low
//   start          level-sampled start request, honoured only in IDLE
//   stop           abort; beats start and beats the end-of-pass transition
//   modo_continuo  1 = wrap after the last address, 0 = single pass
//   reverso        (SEQ_REVERSO_EN only) 1 = descending scan
//   a              registered select to the decoder
//   enable         registered enable to the decoder
//   ocupado        high while a scan is in progress
//   fim            one-cycle pulse when a single pass completes normally
// -----------------------------------------------------------------------------
module sequenciador_varredura #(
    parameter int N_SEL = 3,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             modo_continuo,
`ifdef SEQ_REVERSO_EN
    input  logic             reverso,
`endif
    output logic [N_SEL-1:0] a,
    output logic             enable,
    output logic             ocupado,
    output logic             fim
);

    localparam int CW = $clog2(DWELL) + 1;
    localparam logic [N_SEL-1:0] A_MAX   = {N_SEL{1'b1}};
    localparam logic [CW-1:0]    CNT_END = CW'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, ATIVO, FIM} estado_t;

    estado_t          estado_reg, estado_next;
    logic [N_SEL-1:0] a_reg, a_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             enable_reg, enable_next;
    logic             ocupado_reg, ocupado_next;
    logic             fim_reg, fim_next;
    logic             desc_reg, desc_next;   // latched scan direction (1 = down)
    logic             start_desc;            // direction requested on the start edge

`ifdef SEQ_REVERSO_EN
    assign start_desc = reverso;
`else
    assign start_desc = 1'b0;
`endif

    // First and last address of a pass depend on the latched direction.
    logic [N_SEL-1:0] a_first, a_last;
    assign a_first = desc_reg ? A_MAX : '0;
    assign a_last  = desc_reg ? '0 : A_MAX;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_reg  <= IDLE;
            a_reg       <= '0;
            cnt_reg     <= '0;
            enable_reg  <= 1'b0;
            ocupado_reg <= 1'b0;
            fim_reg     <= 1'b0;
            desc_reg    <= 1'b0;
        end else begin
            estado_reg  <= estado_next;
            a_reg       <= a_next;
            cnt_reg     <= cnt_next;
            enable_reg  <= enable_next;
            ocupado_reg <= ocupado_next;
            fim_reg     <= fim_next;
            desc_reg    <= desc_next;
        end
    end

    always_comb begin
        estado_next  = estado_reg;
        a_next       = a_reg;
        cnt_next     = cnt_reg;
        enable_next  = enable_reg;
        ocupado_next = ocupado_reg;
        fim_next     = 1'b0;
        desc_next    = desc_reg;

        case (estado_reg)
            IDLE: begin
                a_next       = '0;
                enable_next  = 1'b0;
                ocupado_next = 1'b0;
                cnt_next     = '0;
                if (start && !stop) begin
                    estado_next  = ATIVO;
                    a_next       = start_desc ? A_MAX : '0;
                    enable_next  = 1'b1;
                    ocupado_next = 1'b1;
                    desc_next    = start_desc;
                end
            end

            ATIVO: begin
                if (stop) begin
                    // Abort wins even on the end-of-pass edge: no fim pulse.
                    estado_next  = IDLE;
                    a_next       = '0;
                    enable_next  = 1'b0;
                    ocupado_next = 1'b0;
                    cnt_next     = '0;
                end else if (cnt_reg == CNT_END) begin
                    cnt_next = '0;
                    if (a_reg == a_last) begin
                        if (modo_continuo) begin
                            a_next = a_first;   // wrap with enable held high
                        end else begin
                            estado_next  = FIM;
                            a_next       = '0;
                            enable_next  = 1'b0;
                            ocupado_next = 1'b0;
                            fim_next     = 1'b1;
                        end
                    end else begin
                        a_next = desc_reg ? (a_reg - N_SEL'(1)) : (a_reg + N_SEL'(1));
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end

            FIM: begin
                // Single-cycle completion state; start is not looked at here.
                estado_next  = IDLE;
                a_next       = '0;
                enable_next  = 1'b0;
                ocupado_next = 1'b0;
                cnt_next     = '0;
            end

            default: begin
                estado_next  = IDLE;
                a_next       = '0;
                enable_next  = 1'b0;
                ocupado_next = 1'b0;
                cnt_next     = '0;
            end
        endcase
    end

    assign a       = a_reg;
    assign enable  = enable_reg;
    assign ocupado = ocupado_reg;
    assign fim     = fim_reg;

endmodule
